branch_predict_ctrl: RTL and testbench

- Direct-mapped branch target buffer plus controller for an array of ENTRIES 2-bit branch counters, one per entry.
- Serves a combinational lookup port to IF and a registered update port from EX.
- Sequences a multi-cycle table clear after a pipeline flush or context change.
- Arbitrates the clear walker against EX updates and IF lookups; optional statistics counters.

---
 rtl/branch_predict_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit direction counters, update port and multi-cycle clear walker.
// Optional saturating statistics counters are enabled by defining BP_STATS_EN.
module branch_predict_ctrl #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_update,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  output logic              ex_mispredict,
  input  logic              clr_req,
  output logic              clr_busy
`ifdef BP_STATS_EN
  ,
  output logic [15:0]       stat_updates,
  output logic [15:0]       stat_mispredicts
`endif
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [0:0] {StIdle, StClear} st_e;

  st_e              st_q, st_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         state_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             blocked, if_hit, ex_hit, upd_we;
  logic [1:0]       upd_state;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];

  assign clr_busy = (st_q == StClear);
  // A pending request blocks the table in the same cycle so no update races the walk start.
  assign blocked  = clr_busy | clr_req;

  // Lookup is zero-latency and reads pre-update contents (no bypass).
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_hit    = if_hit & ~blocked;
  assign pred_taken  = pred_hit & state_q[if_idx][1];
  assign pred_target = pred_hit ? target_q[if_idx] : '0;

  assign ex_mispredict = ex_update & (ex_taken != ex_pred_taken);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd_we = ex_update & ~blocked & (ex_hit | ex_taken);

  always_comb begin
    upd_state = 2'd1;
    if (ex_hit) begin
      unique case (state_q[ex_idx])
        2'd0:    upd_state = ex_taken ? 2'd1 : 2'd0;
        2'd1:    upd_state = ex_taken ? 2'd2 : 2'd0;
        2'd2:    upd_state = ex_taken ? 2'd2 : 2'd3;
        default: upd_state = ex_taken ? 2'd2 : 2'd0;
      endcase
    end
  end

  always_comb begin
    st_d      = st_q;
    clr_idx_d = clr_idx_q;
    unique case (st_q)
      StIdle: begin
        if (clr_req) begin
          st_d      = StClear;
          clr_idx_d = '0;
        end
      end
      default: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(ENTRIES - 1)) st_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= StIdle;
      clr_idx_q <= '0;
    end else begin
      st_q      <= st_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) state_q[i] <= 2'd0;
    end else if (clr_busy) begin
      valid_q[clr_idx_q] <= 1'b0;
      state_q[clr_idx_q] <= 2'd0;
    end else if (upd_we) begin
      valid_q[ex_idx] <= 1'b1;
      state_q[ex_idx] <= upd_state;
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_we) begin
      if (!ex_hit) tag_q[ex_idx] <= ex_tag;
      if (ex_taken) target_q[ex_idx] <= ex_target;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] stat_upd_q, stat_mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (ex_update && stat_upd_q != 16'hFFFF) stat_upd_q <= stat_upd_q + 16'd1;
      if (ex_mispredict && stat_mis_q != 16'hFFFF) stat_mis_q <= stat_mis_q + 16'd1;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed test-plan steps plus random traffic
// against a behavioural table model. Define BP_STATS_EN to also exercise the statistics.
module tb_branch_predict_ctrl;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ADDR_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] if_pc, ex_pc, ex_target, pred_target;
  logic              pred_hit, pred_taken, ex_update, ex_taken, ex_pred_taken;
  logic              ex_mispredict, clr_req, clr_busy;
`ifdef BP_STATS_EN
  logic [15:0]       stat_updates, stat_mispredicts;
`endif

  branch_predict_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_update     (ex_update),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_mispredict (ex_mispredict),
    .clr_req       (clr_req),
    .clr_busy      (clr_busy)
`ifdef BP_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: per-entry fields, remaining clear cycles and walk position.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_state  [ENTRIES];
  int          m_busy, m_pos, m_upd, m_mis;
  int          nt_next [4] = '{0, 0, 3, 0};
  int          t_next  [4] = '{1, 2, 2, 2};

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_state[i] = 0;
    end
    m_busy = 0; m_pos = 0; m_upd = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    bit blocked;
    int i;
    blocked = (m_busy > 0) || clr_req;
    if (ex_update && m_upd < 65535) m_upd++;
    if (ex_update && (ex_taken != ex_pred_taken) && m_mis < 65535) m_mis++;
    if (ex_update && !blocked) begin
      i = idx_of(ex_pc);
      if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
        m_state[i] = ex_taken ? t_next[m_state[i]] : nt_next[m_state[i]];
        if (ex_taken) m_target[i] = ex_target;
      end else if (ex_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_target[i] = ex_target; m_state[i] = 1;
      end
    end
    if (m_busy > 0) begin
      m_valid[m_pos] = 1'b0; m_state[m_pos] = 0; m_pos++; m_busy--;
    end else if (clr_req) begin
      m_busy = ENTRIES; m_pos = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int  i;
    bit  hit;
    i   = idx_of(if_pc);
    hit = !((m_busy > 0) || clr_req) && m_valid[i] && m_tag[i] == tag_of(if_pc);
    chk("pred_hit", {31'd0, pred_hit}, {31'd0, hit});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, hit && m_state[i] >= 2});
    chk("pred_target", pred_target, hit ? m_target[i] : 32'd0);
    chk("ex_mispredict", {31'd0, ex_mispredict}, {31'd0, ex_update && (ex_taken != ex_pred_taken)});
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_busy > 0});
`ifdef BP_STATS_EN
    chk("stat_updates", {16'd0, stat_updates}, m_upd);
    chk("stat_mispredicts", {16'd0, stat_mispredicts}, m_mis);
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ipc, input bit u, input logic [31:0] epc, input bit t,
                       input logic [31:0] tgt, input bit p, input bit c);
    if_pc = ipc; ex_update = u; ex_pc = epc; ex_taken = t; ex_target = tgt;
    ex_pred_taken = p; clr_req = c;
    #1;
    check_all();
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    drive(pc, 1'b1, pc, t, tgt, 1'b0, 1'b0);
    tick();
  endtask

  task automatic look(input logic [31:0] pc, input bit h, input bit t, input logic [31:0] tgt);
    drive(pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("look_hit", {31'd0, pred_hit}, {31'd0, h});
    chk("look_taken", {31'd0, pred_taken}, {31'd0, t});
    chk("look_target", pred_target, tgt);
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    int busy_cycles;
`ifdef BP_STATS_EN
    int u0, m0;
`endif
    rst = 1'b0;
    model_reset();
    if_pc = 32'h40; ex_update = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    ex_pred_taken = 0; clr_req = 0;
    #1;
    check_all();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    look(32'h40, 0, 0, 0);
    upd(32'h40, 1, 32'h100);
    look(32'h40, 1, 0, 32'h100);
    upd(32'h40, 1, 32'h100);
    look(32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    look(32'h40, 1, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    look(32'h40, 1, 0, 32'h100);
    upd(32'h40, 1, 32'h100);
    look(32'h40, 1, 0, 32'h100);
    upd(32'h40, 1, 32'h100);
    look(32'h40, 1, 1, 32'h100);

    // Alias on index 0 with a different tag replaces the entry.
    upd(32'h80, 1, 32'h200);
    look(32'h40, 0, 0, 0);
    look(32'h80, 1, 0, 32'h200);
    upd(32'h44, 0, 32'h300);
    look(32'h44, 0, 0, 0);

`ifdef BP_STATS_EN
    u0 = stat_updates; m0 = stat_mispredicts;
    drive(32'h0, 1, 32'h500, 1, 32'h600, 0, 0); tick();
    drive(32'h0, 1, 32'h500, 1, 32'h600, 1, 0); tick();
    drive(32'h0, 1, 32'h500, 0, 32'h600, 1, 0); tick();
    #1;
    chk("stat_upd_delta", stat_updates - u0, 3);
    chk("stat_mis_delta", stat_mispredicts - m0, 2);
`endif

    // Clear walk with a dropped update on cycle 5 and a second request mid-walk.
    upd(32'h100, 1, 32'hA00);
    upd(32'h104, 1, 32'hA04);
    upd(32'h108, 1, 32'hA08);
    drive(32'h100, 0, 0, 0, 0, 0, 1);
    chk("clr_req_blocks", {31'd0, pred_hit}, 32'd0);
    tick();
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      drive(32'h100 + 32'(i % 4) * 4, i == 4, 32'h10C, 1, 32'hBAD, 0, i == 8);
      if (clr_busy) busy_cycles++;
      tick();
    end
    chk("clr_busy_len", busy_cycles, ENTRIES);
    look(32'h100, 0, 0, 0);
    look(32'h108, 0, 0, 0);
    look(32'h10C, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      drive(rand_pc(), $urandom_range(0, 9) < 6, rand_pc(), 1'($urandom), $urandom,
            1'($urandom), $urandom_range(0, 60) == 0);
      tick();
    end

    // Reset in the middle of a walk.
    drive(32'h0, 0, 0, 0, 0, 0, 1); tick();
    repeat (5) begin drive(32'h100, 1, 32'h100, 1, 32'h1, 0, 0); tick(); end
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
`ifdef BP_STATS_EN
    chk("rst_stat_upd", {16'd0, stat_updates}, 32'd0);
    chk("rst_stat_mis", {16'd0, stat_mispredicts}, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    look(32'h100, 0, 0, 0);
    for (int i = 0; i < int'(ENTRIES); i++) look(32'h40 * 32'($urandom_range(0, 3)) + 32'(i) * 4, 0, 0, 0);

`ifdef BP_STATS_EN
    if_pc = 0; ex_update = 1; ex_taken = 1; ex_pred_taken = 0; clr_req = 0;
    for (int n = 0; n < 65540; n++) begin
      ex_pc = rand_pc();
      tick();
    end
    ex_update = 0;
    #1;
    check_all();
    chk("stat_upd_sat", {16'd0, stat_updates}, 32'hFFFF);
    chk("stat_mis_sat", {16'd0, stat_mispredicts}, 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
